// File: rtl/ahb_lite_master_if.sv
// ============================================================================
//  Module      : ahb_lite_master_if
//  Description : Command/response stream plus AHB-Lite bus signals of the
//                single-transfer master.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ahb_lite_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTERLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTERLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTERLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_master.sv
// ============================================================================
//  Module      : ahb_lite_master
//  Description : Single-transfer AHB-Lite master turning a valid/ready command
//                stream into pipelined NONSEQ SINGLE transfers, with an
//                in-order response pulse and a data-phase stall watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ahb_lite_master #(
    parameter logic [3:0]  HPROT_VAL   = 4'b0011,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             hang_clr,
    output logic             hang_flag,
    ahb_lite_master_if.master bus
);

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;

    // Address-phase stage
    logic        r_a_vld;
    logic        r_a_write;
    logic [31:0] r_a_addr;
    logic [2:0]  r_a_size;
    logic [31:0] r_a_wdata;
    // Data-phase stage
    logic        r_d_vld;
    logic        r_d_write;
    logic [31:0] r_d_wdata;
    // Response registers
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_cmd_ready;
    logic        w_accept;
    logic        w_complete;
    logic [2:0]  w_size_clamped;

    assign w_cmd_ready    = !r_a_vld || bus.HREADY;
    assign w_accept       = bus.cmd_valid && w_cmd_ready;
    assign w_complete     = r_d_vld && bus.HREADY;
    assign w_size_clamped = (bus.cmd_size > 3'd2) ? 3'd2 : bus.cmd_size;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_a_vld   <= 1'b0;
            r_a_write <= 1'b0;
            r_a_addr  <= '0;
            r_a_size  <= '0;
            r_a_wdata <= '0;
        end else if (w_accept) begin
            r_a_vld   <= 1'b1;
            r_a_write <= bus.cmd_write;
            r_a_addr  <= bus.cmd_addr;
            r_a_size  <= w_size_clamped;
            r_a_wdata <= bus.cmd_wdata;
        end else if (bus.HREADY) begin
            r_a_vld   <= 1'b0;
        end
    end

    // A hands over to D on the same edge that may load a new command into A.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_d_vld   <= 1'b0;
            r_d_write <= 1'b0;
            r_d_wdata <= '0;
        end else if (bus.HREADY) begin
            r_d_vld   <= r_a_vld;
            r_d_write <= r_a_write;
            r_d_wdata <= r_a_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_complete;
            if (w_complete) begin
                r_rsp_err   <= bus.HRESP;
                r_rsp_rdata <= r_d_write ? 32'd0 : bus.HRDATA;
            end
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_rdata   = r_rsp_rdata;

    assign bus.HTRANS      = r_a_vld ? c_htrans_nonseq : c_htrans_idle;
    assign bus.HADDR       = r_a_vld ? r_a_addr  : 32'd0;
    assign bus.HWRITE      = r_a_vld ? r_a_write : 1'b0;
    assign bus.HSIZE       = r_a_vld ? r_a_size  : 3'd0;
    assign bus.HWDATA      = (r_d_vld && r_d_write) ? r_d_wdata : 32'd0;
    assign bus.HBURST      = 3'b000;
    assign bus.HPROT       = HPROT_VAL;
    assign bus.HMASTERLOCK = 1'b0;

    generate
        if (TIMEOUT_CYC > 0) begin : g_wdog
            logic [15:0] r_stall_cnt;
            logic        r_hang;
            logic        w_stall;
            logic [15:0] w_cnt_next;

            assign w_stall    = r_d_vld && !bus.HREADY;
            assign w_cnt_next = (r_stall_cnt == 16'hFFFF) ? r_stall_cnt : r_stall_cnt + 16'd1;

            // Flag rises on the edge where the stall count reaches the limit.
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    r_stall_cnt <= '0;
                    r_hang      <= 1'b0;
                end else begin
                    r_stall_cnt <= w_stall ? w_cnt_next : 16'd0;
                    if (hang_clr)
                        r_hang <= 1'b0;
                    else if (w_stall && (32'(w_cnt_next) >= TIMEOUT_CYC))
                        r_hang <= 1'b1;
                end
            end

            assign hang_flag = r_hang;
        end else begin : g_no_wdog
            logic w_unused_hang_clr;
            assign w_unused_hang_clr = hang_clr;
            assign hang_flag         = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
// Directed scenarios plus a randomized command stream against a command-level
// reference (memory image + expected response queue) and a behavioural AHB slave.
`timescale 1ns/1ps
`default_nettype none

module tb_ahb_lite_master;

    localparam int unsigned TO = 8;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    logic hang_clr = 1'b0;
    logic hang_flag;

    ahb_lite_master_if bus ();

    ahb_lite_master #(.HPROT_VAL(4'b0011), .TIMEOUT_CYC(TO)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .hang_clr (hang_clr),
        .hang_flag(hang_flag),
        .bus      (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        logic        err;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        logic        chk_lat;
    } rsp_t;

    xfer_t       issue_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] model_mem[16];
    logic [31:0] slv_mem[16];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave and output monitor ----------------
    logic        dp_act = 1'b0;
    xfer_t       dp;
    xfer_t       nx;
    rsp_t        er;
    int          wait_left = 0;
    logic        err_stage = 1'b0;
    logic        prev_rdy = 1'b1;
    logic [1:0]  prev_trans = 2'b00;
    logic [31:0] prev_addr = '0;
    logic        prev_write = 1'b0;
    logic [2:0]  prev_size = '0;
    int          stall_run = 0;
    logic        model_hang = 1'b0;
    int          nonseq_cycles = 0;
    int          run = 0;
    int          max_run = 0;
    int          rsp_cnt = 0;

    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
        forever begin
            @(negedge HCLK);
            check("hang_flag", hang_flag, model_hang);
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    er = rsp_q.pop_front();
                    check("rsp_err", bus.rsp_err, er.err);
                    check("rsp_rdata", bus.rsp_rdata, er.rdata);
                    if (er.chk_lat) check("rsp_latency", 64'(cyc - er.acc_cyc), 3);
                end
            end
            check("htrans_legal", (bus.HTRANS == 2'b00 || bus.HTRANS == 2'b10), 1);
            if (bus.HTRANS == 2'b00) check("idle_addr", {bus.HADDR, bus.HWRITE, bus.HSIZE}, 0);
            if (!prev_rdy && prev_trans == 2'b10)
                check("addr_hold", {bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE},
                      {2'b10, prev_addr, prev_write, prev_size});
            check("hwdata", bus.HWDATA, (dp_act && dp.write) ? dp.wdata : 32'd0);

            bus.HRDATA = $urandom;
            bus.HRESP  = 1'b0;
            bus.HREADY = 1'b1;
            if (dp_act) begin
                if (wait_left > 0) bus.HREADY = 1'b0;
                else if (dp.err && !err_stage) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = 1'b1;
                end else begin
                    bus.HRESP = dp.err;
                    if (!dp.write) bus.HRDATA = slv_mem[dp.addr[5:2]];
                end
            end

            #3;
            if (!HRESETn) begin
                dp_act = 1'b0;
                issue_q.delete();
                rsp_q.delete();
                stall_run = 0;
                model_hang = 1'b0;
                prev_rdy = 1'b1;
                prev_trans = 2'b00;
                run = 0;
            end else begin
                if (dp_act && !bus.HREADY) stall_run++;
                else stall_run = 0;
                if (hang_clr) model_hang = 1'b0;
                else if (stall_run >= int'(TO)) model_hang = 1'b1;

                prev_rdy   = bus.HREADY;
                prev_trans = bus.HTRANS;
                prev_addr  = bus.HADDR;
                prev_write = bus.HWRITE;
                prev_size  = bus.HSIZE;
                if (bus.HTRANS == 2'b10) begin
                    nonseq_cycles++;
                    run++;
                    if (run > max_run) max_run = run;
                end else run = 0;

                if (dp_act) begin
                    if (bus.HREADY) begin
                        if (dp.write && !dp.err) slv_mem[dp.addr[5:2]] = bus.HWDATA;
                        dp_act = 1'b0;
                    end else if (wait_left > 0) wait_left--;
                    else err_stage = 1'b1;
                end
                if (bus.HREADY && bus.HTRANS == 2'b10) begin
                    if (issue_q.size() == 0) check("issue_unexpected", 1, 0);
                    else begin
                        nx = issue_q.pop_front();
                        check("haddr", bus.HADDR, nx.addr);
                        check("hwrite", bus.HWRITE, nx.write);
                        check("hsize", bus.HSIZE, nx.size);
                        dp = nx;
                        dp_act = 1'b1;
                        wait_left = nx.waits;
                        err_stage = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- command driver with reference model ----------------
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int waits, input logic err,
                        input logic chk_lat, output int tries);
        xfer_t x;
        rsp_t  r;
        bit    done = 0;
        @(negedge HCLK);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = sz;
        bus.cmd_wdata = wd;
        tries = 0;
        while (!done) begin
            #1;
            tries++;
            if (bus.cmd_ready) begin
                x.write = w;
                x.addr  = a;
                x.size  = (sz > 3'd2) ? 3'd2 : sz;
                x.wdata = wd;
                x.waits = waits;
                x.err   = err;
                issue_q.push_back(x);
                r.rdata   = w ? 32'd0 : model_mem[a[5:2]];
                r.err     = err;
                r.acc_cyc = cyc;
                r.chk_lat = chk_lat;
                rsp_q.push_back(r);
                if (w && !err) model_mem[a[5:2]] = wd;
                done = 1;
            end
            @(posedge HCLK);
            if (!done) begin
                if (tries > 100) begin
                    check("accept_timeout", 0, 1);
                    done = 1;
                end else begin
                    @(negedge HCLK);
                    #1;
                end
            end
        end
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || issue_q.size() != 0) && n < 300) begin
            @(negedge HCLK);
            n++;
        end
        check("drain", (n < 300), 1);
        repeat (2) @(negedge HCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;
        int c0;
        int rw;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
            slv_mem[i]   = '0;
        end

        repeat (2) @(negedge HCLK);
        #1;
        check("rst_htrans", bus.HTRANS, 2'b00);
        check("rst_haddr", bus.HADDR, 0);
        check("rst_hwdata", bus.HWDATA, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_hang", hang_flag, 0);
        check("hburst", bus.HBURST, 3'b000);
        check("hprot", bus.HPROT, 4'b0011);
        check("hmasterlock", bus.HMASTERLOCK, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);

        // 1: write with one wait state
        nonseq_cycles = 0;
        send(1'b1, 32'h04, 3'd2, 32'hDEADBEEF, 1, 1'b0, 1'b0, t);
        check("t1_first_try", t, 1);
        wait_idle();
        check("t1_nonseq_cycles", nonseq_cycles, 1);

        // 2: read back with two wait states
        c0 = rsp_cnt;
        send(1'b0, 32'h04, 3'd2, 32'd0, 2, 1'b0, 1'b0, t);
        wait_idle();
        check("t2_rsp_count", rsp_cnt - c0, 1);

        // 3: four back-to-back zero-wait writes
        nonseq_cycles = 0;
        max_run = 0;
        c0 = rsp_cnt;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 32'(i * 4), 3'd2, $urandom, 0, 1'b0, 1'b1, t);
            check("t3_ready", t, 1);
        end
        wait_idle();
        check("t3_nonseq_cycles", nonseq_cycles, 4);
        check("t3_max_run", max_run, 4);
        check("t3_rsp_count", rsp_cnt - c0, 4);

        // 4: ERROR on the first of two reads
        send(1'b0, 32'h08, 3'd2, 32'd0, 0, 1'b1, 1'b0, t);
        send(1'b0, 32'h0C, 3'd2, 32'd0, 0, 1'b0, 1'b0, t);
        wait_idle();

        // 5: ten-cycle stall trips the watchdog
        send(1'b1, 32'h10, 3'd2, $urandom, 10, 1'b0, 1'b0, t);
        wait_idle();
        check("t5_hang_set", hang_flag, 1);
        @(negedge HCLK);
        #1 hang_clr = 1'b1;
        @(negedge HCLK);
        #1 hang_clr = 1'b0;
        @(negedge HCLK);
        #1 check("t5_hang_clr", hang_flag, 0);

        // 6: reset during a stalled data phase
        send(1'b0, 32'h14, 3'd2, 32'd0, 20, 1'b0, 1'b0, t);
        repeat (3) @(negedge HCLK);
        #1 HRESETn = 1'b0;
        #1;
        check("t6_htrans", bus.HTRANS, 2'b00);
        check("t6_hwdata", bus.HWDATA, 0);
        check("t6_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(negedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
        check("t6_cmd_ready", bus.cmd_ready, 1);
        check("t6_htrans_after", bus.HTRANS, 2'b00);
        c0 = rsp_cnt;
        repeat (5) @(negedge HCLK);
        check("t6_no_rsp", rsp_cnt - c0, 0);

        // randomized stream
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge HCLK);
            rw = int'($urandom_range(0, 1));
            send(rw[0], 32'($urandom_range(0, 15)) << 2, 3'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b0, t);
        end
        wait_idle();
        check("final_hang", hang_flag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
